// File: rtl/bin_ascii_serializer_if.sv
// Handshake bundle between the word source, the serializer and the UART TX FIFO.
// The slave side is the serializer; the master side is whatever drives the
// request and observes the FIFO write strobe (a controller or a testbench).
interface bin_ascii_serializer_if #(
  parameter int N = 8,
  parameter int B = 8
);

  logic         start;
  logic [N-1:0] din;
  logic         tx_full;
  logic         wr;
  logic [B-1:0] w_data;
  logic         busy;
  logic         done_tick;

  modport master (
    output start,
    output din,
    output tx_full,
    input  wr,
    input  w_data,
    input  busy,
    input  done_tick
  );

  modport slave (
    input  start,
    input  din,
    input  tx_full,
    output wr,
    output w_data,
    output busy,
    output done_tick
  );

endinterface

// File: rtl/bin_ascii_serializer.sv
// Binary word to ASCII '1'/'0' serializer feeding a UART TX FIFO.
// Emits din MSB first as 0x31/0x30 characters, optionally followed by CR LF,
// one character per cycle in which the FIFO is not full.
module bin_ascii_serializer #(
  parameter int N   = 8,
  parameter int B   = 8,
  parameter bit EOL = 1'b1
) (
  input logic                clk,
  input logic                reset,
  bin_ascii_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  localparam logic [B-1:0] CH_ZERO = B'(8'h30);
  localparam logic [B-1:0] CH_ONE  = B'(8'h31);
  localparam logic [B-1:0] CH_CR   = B'(8'h0D);
  localparam logic [B-1:0] CH_LF   = B'(8'h0A);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BITS = 3'd1,
    CR   = 3'd2,
    LF   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] cnt;

  logic write_state;
  logic wr_en;
  logic last_bit;

  // A character leaves only in a write state with room in the FIFO; while the
  // FIFO is full nothing advances, so no character is lost or repeated.
  assign write_state = (state == BITS) || (state == CR) || (state == LF);
  assign wr_en       = write_state && !bus.tx_full;
  assign last_bit    = (cnt == CNT_W'(1));

  // State register with synchronous reset; reset wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register and bit counter: load on accepted start, advance per write.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        shreg <= bus.din;
        cnt   <= CNT_W'(N);
      end
    end else if (state == BITS && wr_en) begin
      shreg <= shreg << 1;
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Next-state logic: advance only on a written character.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (bus.start) state_next = BITS;
      BITS: if (wr_en && last_bit) state_next = EOL ? CR : DONE;
      CR:   if (wr_en) state_next = LF;
      LF:   if (wr_en) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: character select, write strobe, status flags.
  always_comb begin
    bus.wr        = wr_en;
    bus.busy      = (state != IDLE);
    bus.done_tick = (state == DONE);
    bus.w_data    = CH_ZERO;
    unique case (state)
      BITS:    bus.w_data = shreg[N-1] ? CH_ONE : CH_ZERO;
      CR:      bus.w_data = CH_CR;
      LF:      bus.w_data = CH_LF;
      default: bus.w_data = CH_ZERO;
    endcase
  end

endmodule

// File: tb/tb_bin_ascii_serializer.sv
// Self-checking bench for bin_ascii_serializer: EOL=1 instance driven from a
// vector table plus hand sequences, EOL=0 instance for back-to-back words.
module tb_bin_ascii_serializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bin_ascii_serializer_if #(.N(8), .B(8)) bus_a ();
  bin_ascii_serializer_if #(.N(8), .B(8)) bus_b ();

  bin_ascii_serializer #(.N(8), .B(8), .EOL(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  bin_ascii_serializer #(.N(8), .B(8), .EOL(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_words[$];
  logic [7:0] rx_word = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected character stream for one word on the EOL=1 instance.
  function automatic void push_word_a(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q_a.push_back(w[i] ? 8'h31 : 8'h30);
    q_a.push_back(8'h0D);
    q_a.push_back(8'h0A);
    exp_words.push_back(w);
  endfunction

  // Scoreboard for instance A, plus a receive-collector model rebuilding words.
  always @(negedge clk) begin
    logic [31:0] exp_c;
    logic [31:0] exp_w;
    if (bus_a.wr === 1'b1) begin
      exp_c = (q_a.size() != 0) ? {24'h0, q_a.pop_front()} : 32'hDEAD;
      check("a_char", {24'h0, bus_a.w_data}, exp_c);
      if (bus_a.w_data == 8'h0A) begin
        exp_w = (exp_words.size() != 0) ? {24'h0, exp_words.pop_front()} : 32'hDEAD;
        check("loopback_word", {24'h0, rx_word}, exp_w);
        rx_word = 8'h00;
      end else if (bus_a.w_data == 8'h31 || bus_a.w_data == 8'h30) begin
        rx_word = {rx_word[6:0], bus_a.w_data[0]};
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    logic [31:0] exp_c;
    if (bus_b.wr === 1'b1) begin
      exp_c = (q_b.size() != 0) ? {24'h0, q_b.pop_front()} : 32'hDEAD;
      check("b_char", {24'h0, bus_b.w_data}, exp_c);
    end
  end

  typedef struct {
    logic [7:0]  din;
    logic [31:0] full;      // tx_full per cycle, bit c = cycle c after start
    int          first_wr;
    int          done_at;
    int          ign_at;    // cycle of an extra start pulse with ~din, -1 = none
  } vec_t;

  // One word on instance A: start in cycle 0, observe cycles 1..30.
  task automatic run_word(input vec_t v);
    int first_wr = -1;
    int n_wr     = 0;
    int n_done   = 0;
    int done_c   = -1;
    bit busy_ok  = 1'b1;
    push_word_a(v.din);
    @(posedge clk); #1;
    bus_a.start   = 1'b1;
    bus_a.din     = v.din;
    bus_a.tx_full = v.full[0];
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus_a.start   = (c == v.ign_at);
      bus_a.din     = (c == v.ign_at) ? ~v.din : v.din;
      bus_a.tx_full = v.full[c];
      @(negedge clk);
      if (bus_a.wr === 1'b1) begin
        n_wr++;
        if (first_wr < 0) first_wr = c;
      end
      if (bus_a.done_tick === 1'b1) begin
        n_done++;
        done_c = c;
      end
      if (c <= v.done_at && bus_a.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("first_wr_cycle", first_wr, v.first_wr);
    check("wr_count", n_wr, 10);
    check("done_cycle", done_c, v.done_at);
    check("done_count", n_done, 1);
    check("busy_while_active", {31'h0, busy_ok}, 1);
    check("busy_after_done", {31'h0, bus_a.busy}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int n_done;
    int done1;
    int done2;
    bit no_done;

    vecs[0] = '{din: 8'hA5, full: 32'h0000_0000, first_wr: 1, done_at: 11, ign_at: -1};
    vecs[1] = '{din: 8'h3C, full: 32'h0000_0038, first_wr: 1, done_at: 14, ign_at: -1};
    vecs[2] = '{din: 8'h5A, full: 32'h000A_AAAA, first_wr: 2, done_at: 21, ign_at: -1};
    vecs[3] = '{din: 8'h00, full: 32'h0000_0000, first_wr: 1, done_at: 11, ign_at: -1};
    vecs[4] = '{din: 8'hFF, full: 32'h0000_0000, first_wr: 1, done_at: 11, ign_at: -1};
    vecs[5] = '{din: 8'h00, full: 32'h0000_0000, first_wr: 1, done_at: 11, ign_at: 4};
    vecs[6] = '{din: 8'h81, full: 32'h0000_0000, first_wr: 1, done_at: 11, ign_at: -1};

    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.din = 8'h00; bus_a.tx_full = 1'b0;
    bus_b.start = 1'b0; bus_b.din = 8'h00; bus_b.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_wr", {31'h0, bus_a.wr}, 0);
    check("reset_w_data", {24'h0, bus_a.w_data}, 32'h30);
    check("reset_busy", {31'h0, bus_a.busy}, 0);
    check("reset_done_tick", {31'h0, bus_a.done_tick}, 0);
    check("reset_b_busy", {31'h0, bus_b.busy}, 0);

    // Table: plain words, backpressure patterns, start ignored while busy.
    for (int i = 0; i < 6; i++) run_word(vecs[i]);

    // Reset in cycle 5 of a word: five characters out, then silence.
    push_word_a(8'hC3);
    @(posedge clk); #1;
    bus_a.start = 1'b1; bus_a.din = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      reset = (c == 5);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_wr", {31'h0, bus_a.wr}, 0);
    check("abort_busy", {31'h0, bus_a.busy}, 0);
    check("abort_chars_left", q_a.size(), 5);
    q_a.delete();
    void'(exp_words.pop_back());
    rx_word = 8'h00;
    no_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_a.done_tick !== 1'b0 || bus_a.busy !== 1'b0) no_done = 1'b0;
    end
    check("abort_quiet", {31'h0, no_done}, 1);

    // Reset and start in the same cycle: reset wins.
    @(posedge clk); #1;
    reset = 1'b1; bus_a.start = 1'b1; bus_a.din = 8'h7E;
    @(posedge clk); #1;
    reset = 1'b0; bus_a.start = 1'b0;
    @(negedge clk);
    check("reset_over_start_busy", {31'h0, bus_a.busy}, 0);

    // Fresh word after the abort.
    run_word(vecs[6]);

    // EOL=0 instance, start held high: two words, one IDLE cycle between.
    for (int w = 0; w < 2; w++) for (int i = 0; i < 8; i++) q_b.push_back(8'h31);
    n_done = 0; done1 = -1; done2 = -1;
    @(posedge clk); #1;
    bus_b.start = 1'b1; bus_b.din = 8'hFF;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      bus_b.start = (c < 20);
      @(negedge clk);
      if (bus_b.done_tick === 1'b1) begin
        n_done++;
        if (done1 < 0) done1 = c; else done2 = c;
      end
      if (c == 10) check("b_gap_idle", {31'h0, bus_b.busy}, 0);
    end
    check("b_done_first", done1, 9);
    check("b_done_second", done2, 19);
    check("b_done_count", n_done, 2);
    check("b_chars_left", q_b.size(), 0);

    check("a_chars_left", q_a.size(), 0);
    check("a_words_left", exp_words.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bin_ascii_serializer.md
Name: bin_ascii_serializer

Overview:
Transmit-side companion to the UART receive FIFO and ASCII collector. It takes one N-bit binary word, such as a Hamming-encoded or decoded byte, and emits it as ASCII '1' (0x31) and '0' (0x30) characters, MSB first, followed by an optional CR LF. Characters are written into the UART transmit FIFO through its wr/w_data/full interface. It sits between the Hamming encoder/decoder output and the UART TX FIFO, so a terminal sees the same character format the receive path accepts.

Parameters:
N, 8, number of data bits serialized per word (one ASCII character per bit)
B, 8, width of each character written to the TX FIFO
EOL, 1, 1 = append CR (0x0D) then LF (0x0A) after the bit characters; 0 = no terminator

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to serialize din; sampled only in IDLE
din  input  N  binary word to send; latched on accepted start
tx_full  input  1  full flag from UART TX FIFO; write suppressed while high
wr  output  1  write strobe to TX FIFO, one character per high cycle
w_data  output  B  character presented with wr
busy  output  1  high from the cycle after start is accepted until return to IDLE
done_tick  output  1  one-cycle pulse after the final character has been written

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state=IDLE, shift register=0, counter=0, wr=0, w_data=0x30, busy=0, done_tick=0.
- States:
  - IDLE: start=1 latches din into the shift register, loads bit counter with N, goes to BITS.
  - BITS: presents the current character; on the last bit written, goes to CR if EOL=1, else DONE.
  - CR: presents 0x0D; when written, goes to LF.
  - LF: presents 0x0A; when written, goes to DONE.
  - DONE: done_tick=1 for exactly this cycle; unconditionally returns to IDLE.
- Character mapping in BITS:
  - w_data = 0x31 when the shift register MSB = 1, else 0x30.
  - Bit order is din[N-1] first, din[0] last, so the receive collector rebuilds the same word.
- Write rule (same-cycle, combinational on state and tx_full):
  - wr = 1 in BITS/CR/LF when tx_full=0.
  - When wr=1: the shift register shifts left by one and the counter decrements.
  - When tx_full=1: wr=0 and all state holds; the character is neither dropped nor duplicated.
- w_data is driven from state and the shift register, and is stable in every cycle wr=1. Outside the write states it shows 0x30 and is don't-care to the FIFO.
- Latency:
  - start accepted in cycle 0 -> first wr in cycle 1 (no backpressure).
  - N+2 consecutive wr cycles with EOL=1 (N with EOL=0).
  - done_tick in the cycle after the last wr.
- busy: 1 in BITS/CR/LF/DONE, 0 in IDLE. start while busy=1 is ignored, and a new din is not latched.
- Back-to-back: start held high through DONE is accepted in the following IDLE cycle. Minimum word-to-word gap is one IDLE cycle.
- Counter width: clog2(N+1) bits; the counter never wraps below 0.
- Reset mid-operation: the next edge forces IDLE. No further wr, and no done_tick for the aborted word. Characters already written stay in the FIFO.
- reset has priority over start in the same cycle.
- tx_full may toggle every cycle; each low cycle in a write state produces exactly one character.

Test Plan:
- N=8, EOL=1, din=0xA5, tx_full=0, start pulse cycle 0 -> wr cycles 1..10 with w_data 31,30,31,30,30,31,30,31,0D,0A; done_tick in cycle 11 only; busy 1 in cycles 1..11.
- din=0x3C, tx_full high in cycles 3..5 -> no wr in those cycles; the full character sequence 30,30,31,31,31,31,30,30,0D,0A is still written exactly once; done_tick delayed 3 cycles (cycle 14).
- start pulsed again at cycle 4 with din=0xFF while busy with 0x00 -> only 30x8,0D,0A written; 0xFF is never sent.
- reset asserted in cycle 5 mid-word -> wr=0 from cycle 6, busy=0, no done_tick; a new start of 0x81 then yields 31,30,30,30,30,30,30,31,0D,0A.
- EOL=0, din=0xFF, start held high continuously -> eight 0x31 writes, done_tick, one IDLE cycle, then the next word starts; no 0D/0A ever written.
- Loopback: output fed through the TX FIFO into the receive FIFO/collector -> the collector's 8-bit output equals the original din for 0x00, 0xFF and 0x5A.
